// File: rtl/i2s_clk_ctrl.sv
// i2s_clk_ctrl
// Timing master for the codec serial port. Derives mclk, sclk and lrck from
// clk. Sequences the start: an mclk-only warm-up, then a frame-aligned start.
// Sequences the stop: the current frame completes before the port idles.
// Also issues single-cycle clk-domain strobes so the rx/tx datapaths never
// look at serial clock edges directly.
//
// State table
//   state   | meaning
//   --------+----------------------------------------------------------------
//   S_IDLE  | all clocks held low, counters cleared, waiting for en
//   S_WARM  | mclk only; leaves after WARM_CYCLES, or at an mclk period end
//           | once en has dropped
//   S_RUN   | mclk, sclk, lrck and strobes running; en low moves to S_DRAIN
//   S_DRAIN | like S_RUN, but stops at the end of the right slot; en high
//           | resumes S_RUN seamlessly
//
// Parameter constraints that the RTL relies on:
//   MCLK_HALF >= 1
//   DATA_WIDTH <= SLOT_BITS-1
//   WARM_CYCLES is a nonzero multiple of 2*MCLK_HALF
// The last constraint puts the first RUN cycle on an mclk rising phase, so
// mclk carries straight through the WARM to RUN hand-over.

module i2s_clk_ctrl #(
    parameter int MCLK_HALF   = 2,
    parameter int SCLK_RATIO  = 4,
    parameter int SLOT_BITS   = 32,
    parameter int DATA_WIDTH  = 24,
    parameter int WARM_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic                         mclk,
    output logic                         sclk,
    output logic                         lrck,
    output logic                         active,
    output logic                         sclk_rise,
    output logic                         sclk_fall,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
    output logic                         chan,
    output logic                         sample_en,
    output logic                         word_done,
    output logic                         frame_start
);

    // sclk half-period in clk cycles, and the period lengths of the counters
    localparam int H    = MCLK_HALF * SCLK_RATIO;
    localparam int MC_N = 2 * MCLK_HALF;
    localparam int C_N  = 2 * H;

    localparam int MC_W = $clog2(MC_N);
    localparam int C_W  = $clog2(C_N);
    localparam int B_W  = $clog2(SLOT_BITS);
    localparam int W_W  = $clog2(WARM_CYCLES);

    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MC_N - 1);
    localparam logic [MC_W-1:0] MC_HALF = MC_W'(MCLK_HALF);
    localparam logic [C_W-1:0]  C_LAST  = C_W'(C_N - 1);
    localparam logic [C_W-1:0]  C_H     = C_W'(H);
    localparam logic [B_W-1:0]  B_LAST  = B_W'(SLOT_BITS - 1);
    localparam logic [B_W-1:0]  B_DW    = B_W'(DATA_WIDTH);
    localparam logic [W_W-1:0]  W_LAST  = W_W'(WARM_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WARM  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;

    // mclk phase: 0..2*MCLK_HALF-1; mclk is high in the first half
    logic [MC_W-1:0] mcnt_q, mcnt_d, mcnt_inc;
    // warm-up cycle count
    logic [W_W-1:0]  wcnt_q, wcnt_d;
    // en has dropped at some point during the current warm-up
    logic            stop_q, stop_d;

    // sclk phase counter c, slot bit index and channel
    logic [C_W-1:0]  c_q, c_d, c_step;
    logic [B_W-1:0]  bit_q, bit_d, bit_step;
    logic            chan_q, chan_d, chan_step;

    logic            mclk_period_end;
    logic            warm_done;
    logic            c_wrap;
    logic            slot_wrap;
    logic            frame_end;
    logic            go_idle;

    // next values of the registered outputs
    logic            active_d, run_d, mclk_d, sclk_d;
    logic            rise_d, fall_d, sen_d, wd_d, fs_d;

    logic            active_q, mclk_q, sclk_q;
    logic            rise_q, fall_q, sen_q, wd_q, fs_q;

    assign mclk_period_end = (mcnt_q == MC_LAST);
    assign mcnt_inc        = mclk_period_end ? '0 : mcnt_q + MC_W'(1);
    assign warm_done       = (wcnt_q == W_LAST);

    assign c_wrap    = (c_q == C_LAST);
    assign slot_wrap = c_wrap && (bit_q == B_LAST);
    // final cycle of the right slot: the only point where the port may stop
    assign frame_end = slot_wrap && chan_q;

    assign c_step    = c_wrap ? '0 : c_q + C_W'(1);
    assign bit_step  = !c_wrap           ? bit_q :
                       (bit_q == B_LAST) ? '0    : bit_q + B_W'(1);
    // lrck toggles on slot wrap, which always lands on an sclk falling cycle
    assign chan_step = chan_q ^ slot_wrap;

    // Next-state and next-output decode for the whole controller
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        wcnt_d  = wcnt_q;
        stop_d  = stop_q;
        c_d     = c_q;
        bit_d   = bit_q;
        chan_d  = chan_q;
        go_idle = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_WARM;
                    mcnt_d  = '0;
                    wcnt_d  = '0;
                    stop_d  = 1'b0;
                end
            end

            S_WARM: begin
                mcnt_d = mcnt_inc;
                wcnt_d = wcnt_q + W_W'(1);
                stop_d = stop_q | ~en;
                // An abort only takes effect at the end of an mclk period, so
                // the codec never sees a runt mclk pulse
                if (mclk_period_end && (stop_q || !en)) begin
                    go_idle = 1'b1;
                end else if (warm_done) begin
                    state_d = S_RUN;
                    c_d     = '0;
                    bit_d   = '0;
                    chan_d  = 1'b0;
                end
            end

            S_RUN, S_DRAIN: begin
                if (!en && frame_end) begin
                    go_idle = 1'b1;
                end else begin
                    state_d = en ? S_RUN : S_DRAIN;
                    mcnt_d  = mcnt_inc;
                    c_d     = c_step;
                    bit_d   = bit_step;
                    chan_d  = chan_step;
                end
            end

            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (go_idle) begin
            state_d = S_IDLE;
            mcnt_d  = '0;
            wcnt_d  = '0;
            stop_d  = 1'b0;
            c_d     = '0;
            bit_d   = '0;
            chan_d  = 1'b0;
        end

        // Outputs follow the next state so that every port comes from a flop
        active_d = (state_d != S_IDLE);
        run_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
        mclk_d   = active_d && (mcnt_d < MC_HALF);
        sclk_d   = run_d && (c_d >= C_H);
        rise_d   = run_d && (c_d == C_H);
        fall_d   = run_d && (c_d == '0);
        // bit 0 is the I2S one-bit delay after the lrck edge; payload is 1..DW
        sen_d    = rise_d && (bit_d != '0) && (bit_d <= B_DW);
        wd_d     = rise_d && (bit_d == B_DW);
        fs_d     = fall_d && (bit_d == '0) && !chan_d;
    end

    // State, counters and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            mcnt_q   <= '0;
            wcnt_q   <= '0;
            stop_q   <= 1'b0;
            c_q      <= '0;
            bit_q    <= '0;
            chan_q   <= 1'b0;
            active_q <= 1'b0;
            mclk_q   <= 1'b0;
            sclk_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sen_q    <= 1'b0;
            wd_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcnt_q   <= mcnt_d;
            wcnt_q   <= wcnt_d;
            stop_q   <= stop_d;
            c_q      <= c_d;
            bit_q    <= bit_d;
            chan_q   <= chan_d;
            active_q <= active_d;
            mclk_q   <= mclk_d;
            sclk_q   <= sclk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sen_q    <= sen_d;
            wd_q     <= wd_d;
            fs_q     <= fs_d;
        end
    end

    assign mclk        = mclk_q;
    assign sclk        = sclk_q;
    assign lrck        = chan_q;
    assign chan        = chan_q;
    assign active      = active_q;
    assign sclk_rise   = rise_q;
    assign sclk_fall   = fall_q;
    assign bit_idx     = bit_q;
    assign sample_en   = sen_q;
    assign word_done   = wd_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Bench for i2s_clk_ctrl: a default instance and a small-ratio instance share
// stimulus. Both are compared every cycle against an elapsed-time model, with
// directed timing checks layered on top.

module tb_i2s_clk_ctrl;

    localparam int A_M = 2, A_R = 4, A_SB = 32, A_DW = 24, A_W = 256;
    localparam int B_M = 1, B_R = 2, B_SB = 24, B_DW = 23, B_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    logic       a_mclk, a_sclk, a_lrck, a_active, a_rise, a_fall;
    logic       a_chan, a_sen, a_wd, a_fs;
    logic [4:0] a_bit;
    logic       b_mclk, b_sclk, b_lrck, b_active, b_rise, b_fall;
    logic       b_chan, b_sen, b_wd, b_fs;
    logic [4:0] b_bit;

    logic [15:0] a_out, b_out, a_prev, a_snap;

    i2s_clk_ctrl #(
        .MCLK_HALF(A_M), .SCLK_RATIO(A_R), .SLOT_BITS(A_SB),
        .DATA_WIDTH(A_DW), .WARM_CYCLES(A_W)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(en),
        .mclk(a_mclk), .sclk(a_sclk), .lrck(a_lrck), .active(a_active),
        .sclk_rise(a_rise), .sclk_fall(a_fall), .bit_idx(a_bit),
        .chan(a_chan), .sample_en(a_sen), .word_done(a_wd),
        .frame_start(a_fs)
    );

    i2s_clk_ctrl #(
        .MCLK_HALF(B_M), .SCLK_RATIO(B_R), .SLOT_BITS(B_SB),
        .DATA_WIDTH(B_DW), .WARM_CYCLES(B_W)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en),
        .mclk(b_mclk), .sclk(b_sclk), .lrck(b_lrck), .active(b_active),
        .sclk_rise(b_rise), .sclk_fall(b_fall), .bit_idx(b_bit),
        .chan(b_chan), .sample_en(b_sen), .word_done(b_wd),
        .frame_start(b_fs)
    );

    assign a_out = {a_active, a_mclk, a_sclk, a_lrck, a_chan, a_rise, a_fall,
                    a_sen, a_wd, a_fs, 1'b0, a_bit};
    assign b_out = {b_active, b_mclk, b_sclk, b_lrck, b_chan, b_rise, b_fall,
                    b_sen, b_wd, b_fs, 1'b0, b_bit};

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Reference model: the port is described only by how long it has been
    // warming (tw) and running (tr); everything else is arithmetic on those.
    localparam int M_IDLE = 0, M_WARM = 1, M_RUN = 2;

    typedef struct {
        int mode;
        int tw;
        int tr;
        bit wstop;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_idle();
        mdl_t n;
        n.mode  = M_IDLE;
        n.tw    = 0;
        n.tr    = 0;
        n.wstop = 1'b0;
        return n;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, bit en_v, bit rst_v,
                                      int m, int h, int sb, int warm);
        int   frame;
        bit   last;
        bit   stopreq;
        mdl_t n;
        n     = s;
        frame = 4 * h * sb;
        if (!rst_v) return mdl_idle();
        last = (s.tr % frame) == frame - 1;
        case (s.mode)
            M_IDLE: begin
                if (en_v) begin
                    n.mode  = M_WARM;
                    n.tw    = 0;
                    n.wstop = 1'b0;
                end
            end
            M_WARM: begin
                stopreq = s.wstop || !en_v;
                if (((s.tw % (2 * m)) == 2 * m - 1) && stopreq) begin
                    n = mdl_idle();
                end else begin
                    n.tw    = s.tw + 1;
                    n.wstop = stopreq;
                    if (s.tw == warm - 1) begin
                        n.mode = M_RUN;
                        n.tr   = 0;
                    end
                end
            end
            default: begin
                if (!en_v && last) begin
                    n = mdl_idle();
                end else begin
                    n.tr = s.tr + 1;
                    n.tw = s.tw + 1;
                end
            end
        endcase
        return n;
    endfunction

    function automatic logic [15:0] mdl_out(mdl_t s, int m, int h, int sb,
                                            int dw);
        int   c, sidx, b, ch;
        logic mc, rise, fall;
        if (s.mode == M_IDLE) return 16'h0000;
        mc = (s.tw % (2 * m)) < m;
        if (s.mode == M_WARM) return {1'b1, mc, 14'b0};
        c    = s.tr % (2 * h);
        sidx = s.tr / (2 * h);
        b    = sidx % sb;
        ch   = (sidx / sb) % 2;
        rise = (c == h);
        fall = (c == 0);
        return {1'b1, mc, (c >= h), ch[0], ch[0], rise, fall,
                rise && (b >= 1) && (b <= dw), rise && (b == dw),
                (s.tr % (4 * h * sb)) == 0, b[5:0]};
    endfunction

    // One clk cycle: advance the model with what the DUT sampled, then
    // compare both instances one time unit after the edge
    task automatic tick();
        @(posedge clk);
        ma = mdl_step(ma, en, rst, A_M, A_M * A_R, A_SB, A_W);
        mb = mdl_step(mb, en, rst, B_M, B_M * B_R, B_SB, B_W);
        #1;
        cyc++;
        a_prev = a_snap;
        a_snap = a_out;
        check_eq("model_a", 32'(a_out), 32'(mdl_out(ma, A_M, A_M * A_R, A_SB, A_DW)));
        check_eq("model_b", 32'(b_out), 32'(mdl_out(mb, B_M, B_M * B_R, B_SB, B_DW)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, fs_cyc, bad, sen_cnt, wd_n, gap, strobes, hold;
        logic lrck_prev;
        ma     = mdl_idle();
        mb     = mdl_idle();
        a_prev = '0;
        a_snap = '0;

        // reset
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) tick();
        check_eq("reset_outs_a", 32'(a_out), 32'h0);
        check_eq("reset_outs_b", 32'(b_out), 32'h0);
        rst = 1'b1;
        tick();

        // start-up latency
        en = 1'b1;
        tick();
        check_eq("mclk_first_high", 32'(a_mclk), 32'd1);
        n = 1;
        while (!a_fs && n < 400) begin tick(); n++; end
        check_eq("warm_to_frame_start", n, 257);
        check_eq("first_lrck", 32'(a_lrck), 32'd0);
        check_eq("first_bit_idx", 32'(a_bit), 32'd0);
        check_eq("first_sclk_fall", 32'(a_fall), 32'd1);
        fs_cyc = cyc;
        n = 0;
        do begin tick(); n++; end while (!a_rise && n < 20);
        check_eq("fall_to_rise", n, 8);

        // three frames of steady running
        bad = 0; sen_cnt = 0; wd_n = 0;
        lrck_prev = a_lrck;
        for (int k = 0; k < 3 * 1024; k++) begin
            tick();
            if (a_fs) begin
                check_eq("frame_period", cyc - fs_cyc, 1024);
                fs_cyc = cyc;
            end
            if ((a_lrck != lrck_prev) && !a_fall) bad++;
            lrck_prev = a_lrck;
            if (a_sen) sen_cnt++;
            if (a_wd) begin
                check_eq("word_done_bit", 32'(a_bit), 32'd24);
                check_eq("word_done_chan", 32'(a_chan), 32'(wd_n % 2));
                wd_n++;
            end
        end
        check_eq("lrck_only_on_fall", bad, 0);
        check_eq("sample_en_count", sen_cnt, 144);
        check_eq("word_done_count", wd_n, 6);

        // drop en at bit 10 of the left slot; the frame must complete
        n = 0;
        while (!(a_fall && a_bit == 5'd10 && !a_chan) && n < 2000) begin
            tick(); n++;
        end
        check_eq("reach_left_bit10", 32'(n < 2000), 32'd1);
        en = 1'b0;
        n  = 0;
        while (a_active && n < 2000) begin tick(); n++; end
        check_eq("drain_length", n, 864);
        check_eq("drain_last_bit", 32'(a_prev[4:0]), 32'd31);
        check_eq("drain_last_chan", 32'(a_prev[11]), 32'd1);
        check_eq("drain_last_sclk", 32'(a_prev[13]), 32'd1);
        check_eq("idle_after_drain", 32'(a_out), 32'h0);
        strobes = 0;
        repeat (20) begin
            tick();
            if (a_rise || a_fall || a_sen || a_wd || a_fs) strobes++;
        end
        check_eq("no_strobes_idle", strobes, 0);

        // drain then resume: no gap, frame cadence unchanged
        en = 1'b1;
        n  = 0;
        while (!a_fs && n < 400) begin tick(); n++; end
        check_eq("restart_latency", n, 257);
        fs_cyc = cyc;
        n = 0;
        while (!(a_fall && a_bit == 5'd5 && !a_chan) && n < 200) begin
            tick(); n++;
        end
        check_eq("reach_left_bit5", n, 80);
        en  = 1'b0;
        gap = 0;
        repeat (100) begin tick(); if (!a_active) gap++; end
        en = 1'b1;
        n  = 0;
        while (!a_fs && n < 2000) begin
            tick(); n++;
            if (!a_active) gap++;
        end
        check_eq("resume_frame_period", cyc - fs_cyc, 1024);
        check_eq("no_idle_gap", gap, 0);

        // one-cycle reset mid-run
        repeat (37) tick();
        rst = 1'b0;
        tick();
        check_eq("rst_mid_run_a", 32'(a_out), 32'h0);
        check_eq("rst_mid_run_b", 32'(b_out), 32'h0);
        rst = 1'b1;
        n   = 0;
        while (!a_fs && n < 400) begin tick(); n++; end
        check_eq("rst_rewarm", n, 257);

        // small-ratio instance: sclk period 4, frame 192, word_done at 23
        n = 0;
        while (!b_fs && n < 400) begin tick(); n++; end
        fs_cyc = cyc;
        n = 0;
        do begin tick(); n++; end while (!b_fs && n < 400);
        check_eq("b_frame_period", cyc - fs_cyc, 192);
        n = 0;
        do begin tick(); n++; end while (!b_fall && n < 20);
        n = 0;
        do begin tick(); n++; end while (!b_fall && n < 20);
        check_eq("b_sclk_period", n, 4);
        n = 0;
        while (!b_wd && n < 400) begin tick(); n++; end
        check_eq("b_word_done_bit", 32'(b_bit), 32'd23);

        // randomized en activity with occasional reset pulses
        for (int k = 0; k < 40; k++) begin
            en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) hold = $urandom_range(1, 12);
            else                           hold = $urandom_range(1, 400);
            repeat (hold) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
